// File: rtl/multiplicador_iterativo_pkg.sv
// Shared ALU package for the Execute stage.
// Holds the multiplier FSM state type, the default ALU datapath width and
// a helper that sizes the iteration counter for a given operand width.
package multiplicador_iterativo_pkg;

    // Default operand/result width of the vector ALU lanes.
    localparam int ALU_WIDTH = 19;

    // Iterative multiplier sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mul_state_t;

    // Counter width able to index every multiplier bit position 0..n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multiplicador_iterativo_if.sv
// Handshake/data bundle between the Execute stage and one multiplier lane.
// master (Execute stage): drives start, A, B; observes busy, done, out,
//                         overflow, car.
// slave  (multiplier):    the reverse directions.
interface multiplicador_iterativo_if
    import multiplicador_iterativo_pkg::*;
    #(parameter int n = ALU_WIDTH);

    logic                start;
    logic signed [n-1:0] A;
    logic signed [n-1:0] B;
    logic                busy;
    logic                done;
    logic        [n-1:0] out;
    logic                overflow;
    logic                car;

    modport master (
        output start, A, B,
        input  busy, done, out, overflow, car
    );

    modport slave (
        input  start, A, B,
        output busy, done, out, overflow, car
    );

endinterface

// File: rtl/multiplicador_iterativo.sv
// Multi-cycle signed multiplier for one Execute-stage ALU lane.
// Radix-2 shift-add over operand magnitudes with a final sign fix-up.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (aborts any multiply in flight)
//   bus  - slave side of multiplicador_iterativo_if:
//          start/A/B in; busy, done (1-cycle pulse), out (low n bits of
//          A*B), overflow (signed product does not fit in n bits), car (0).
// Timing: start accepted on edge E0 -> busy high for cycles E0+1..E0+n+1,
// done high in cycle E0+n+1, next start accepted in cycle E0+n+2.
module multiplicador_iterativo
    import multiplicador_iterativo_pkg::*;
    #(parameter int n = ALU_WIDTH)
    (
        input  logic                      clk,
        input  logic                      rst,
        multiplicador_iterativo_if.slave  bus
    );

    localparam int CW = cnt_width(n);
    localparam int W2 = 2 * n;

    // Two's-complement magnitude; -2^(n-1) maps to 2^(n-1), which fits in
    // the n-bit unsigned result, so no special case is needed.
    function automatic logic [n-1:0] magnitude(input logic [n-1:0] v);
        if (v[n-1]) begin
            return (~v) + n'(1);
        end else begin
            return v;
        end
    endfunction

    mul_state_t      state_r, state_s;
    logic [n-1:0]    mag_a_r, mag_a_s;
    logic [n-1:0]    mag_b_r, mag_b_s;
    logic [W2-1:0]   acc_r,   acc_s;
    logic [CW-1:0]   cnt_r,   cnt_s;
    logic            sign_r,  sign_s;
    logic [n-1:0]    out_r,   out_s;
    logic            ovf_r,   ovf_s;
    logic            busy_r,  busy_s;
    logic            done_r,  done_s;
    logic [W2-1:0]   acc_step_s;
    logic [W2-1:0]   prod_s;
    logic [n:0]      prod_top_s;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath next-value logic.
    // The result is formed from the final accumulator value on the last RUN
    // edge so out/overflow are already registered during the FIX (done)
    // cycle.
    always_comb begin
        state_s    = state_r;
        mag_a_s    = mag_a_r;
        mag_b_s    = mag_b_r;
        acc_s      = acc_r;
        cnt_s      = cnt_r;
        sign_s     = sign_r;
        out_s      = out_r;
        ovf_s      = ovf_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        acc_step_s = acc_r;
        prod_s     = acc_r;
        prod_top_s = prod_s[W2-1:n-1];

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    mag_a_s = magnitude(bus.A);
                    mag_b_s = magnitude(bus.B);
                    sign_s  = bus.A[n-1] ^ bus.B[n-1];
                    acc_s   = {W2{1'b0}};
                    cnt_s   = {CW{1'b0}};
                    busy_s  = 1'b1;
                    state_s = RUN;
                end else begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            end

            RUN: begin
                if (mag_b_r[0]) begin
                    acc_step_s = acc_r + ({{n{1'b0}}, mag_a_r} << cnt_r);
                end else begin
                    acc_step_s = acc_r;
                end
                acc_s   = acc_step_s;
                mag_b_s = mag_b_r >> 1;
                cnt_s   = cnt_r + CW'(1);

                if (cnt_r == CW'(n - 1)) begin
                    // Sign fix-up; negating zero yields zero, so a zero
                    // product never flags overflow.
                    if (sign_r) begin
                        prod_s = (~acc_step_s) + W2'(1);
                    end else begin
                        prod_s = acc_step_s;
                    end
                    // Fits in n bits only if bits 2n-1..n-1 are all equal.
                    prod_top_s = prod_s[W2-1:n-1];
                    out_s      = prod_s[n-1:0];
                    ovf_s      = ~((&prod_top_s) | (~|prod_top_s));
                    done_s     = 1'b1;
                    state_s    = FIX;
                end else begin
                    state_s    = RUN;
                end
            end

            FIX: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end

            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a_r <= {n{1'b0}};
            mag_b_r <= {n{1'b0}};
            acc_r   <= {W2{1'b0}};
            cnt_r   <= {CW{1'b0}};
            sign_r  <= 1'b0;
            out_r   <= {n{1'b0}};
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            mag_a_r <= mag_a_s;
            mag_b_r <= mag_b_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            sign_r  <= sign_s;
            out_r   <= out_s;
            ovf_r   <= ovf_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.out      = out_r;
    assign bus.overflow = ovf_r;
    assign bus.car      = 1'b0;

endmodule

// File: tb/tb_multiplicador_iterativo.sv
// Self-checking bench for multiplicador_iterativo (n = 19).
module tb_multiplicador_iterativo;
    import multiplicador_iterativo_pkg::*;

    localparam int N   = 19;
    localparam int LAT = N + 1;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    multiplicador_iterativo_if #(.n(N)) ifc ();

    multiplicador_iterativo #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: a hung run still reports and stops.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact signed product with plain arithmetic.
    function automatic logic [N:0] ref_mul(input logic signed [N-1:0] a,
                                           input logic signed [N-1:0] b);
        longint      p;
        logic [63:0] pv;
        logic        ov;
        p  = longint'(a) * longint'(b);
        pv = p;
        ov = (p > longint'(262143)) || (p < -longint'(262144));
        return {ov, pv[N-1:0]};
    endfunction

    // Issue one operation and observe 30 cycles after the capture edge.
    task automatic run_op(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                          output logic [N-1:0] o, output logic ov,
                          output int lat, output int dcount);
        @(negedge clk);
        ifc.A = a; ifc.B = b; ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.A = N'($urandom);
        ifc.B = N'($urandom);
        lat = -1; dcount = 0; o = '0; ov = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (ifc.done === 1'b1) begin
                dcount++;
                if (lat < 0) begin
                    lat = k; o = ifc.out; ov = ifc.overflow;
                end
            end
            @(negedge clk);
        end
    endtask

    // Run one op and compare against the model.
    task automatic check_op(input string nm, input logic signed [N-1:0] a,
                            input logic signed [N-1:0] b);
        logic [N-1:0] o;
        logic         ov;
        int           lat, dc;
        logic [N:0]   exp_v;
        exp_v = ref_mul(a, b);
        run_op(a, b, o, ov, lat, dc);
        total++;
        if (o !== exp_v[N-1:0]) begin
            bad++; $display("FAIL %s out: got %h want %h (A=%0d B=%0d)", nm, o, exp_v[N-1:0], a, b);
        end
        total++;
        if (ov !== exp_v[N]) begin
            bad++; $display("FAIL %s overflow: got %b want %b (A=%0d B=%0d)", nm, ov, exp_v[N], a, b);
        end
        total++;
        if (lat !== LAT || dc !== 1) begin
            bad++; $display("FAIL %s latency/pulses: got lat=%0d pulses=%0d want lat=%0d pulses=1", nm, lat, dc, LAT);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({ifc.busy, ifc.done, ifc.overflow, ifc.car} !== 4'b0000 || ifc.out !== '0) begin
            bad++; $display("FAIL reset_state: got busy=%b done=%b ovf=%b car=%b out=%h want all 0",
                            ifc.busy, ifc.done, ifc.overflow, ifc.car, ifc.out);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", ifc.busy, ifc.done);
        end
    endtask

    task automatic test_reset_mid_run();
        int dc;
        @(negedge clk);
        ifc.A = 19'sd5; ifc.B = 19'sd7; ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        total++;
        if (ifc.busy !== 1'b1) begin
            bad++; $display("FAIL busy_after_start: got %b want 1", ifc.busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (ifc.busy !== 1'b0 || ifc.out !== '0 || ifc.overflow !== 1'b0) begin
            bad++; $display("FAIL reset_abort: got busy=%b out=%h ovf=%b want 0 0 0", ifc.busy, ifc.out, ifc.overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        for (int k = 0; k < 25; k++) begin
            if (ifc.done === 1'b1) dc++;
            @(negedge clk);
        end
        total++;
        if (dc !== 0) begin
            bad++; $display("FAIL no_done_after_abort: got %0d pulses want 0", dc);
        end
        check_op("after_abort_5x7", 19'sd5, 19'sd7);
    endtask

    task automatic test_directed();
        check_op("mixed_3x-4", 19'sd3, -19'sd4);
        total++;
        if (ifc.car !== 1'b0 || ifc.out !== 19'h7FFF4) begin
            bad++; $display("FAIL mixed_hold: got car=%b out=%h want 0 7fff4", ifc.car, ifc.out);
        end
        check_op("pos_overflow_1000x1000", 19'sd1000, 19'sd1000);
        total++;
        if (ifc.out !== 19'h74240 || ifc.overflow !== 1'b1) begin
            bad++; $display("FAIL pos_overflow_hold: got out=%h ovf=%b want 74240 1", ifc.out, ifc.overflow);
        end
        check_op("min_x_minus1", -19'sd262144, -19'sd1);
        check_op("min_x_1", -19'sd262144, 19'sd1);
        check_op("zero_x_min", 19'sd0, -19'sd262144);
        check_op("max_x_1", 19'sd262143, 19'sd1);
        check_op("min_x_min", -19'sd262144, -19'sd262144);
    endtask

    task automatic test_start_while_busy();
        int           dc;
        logic [N-1:0] o;
        @(negedge clk);
        ifc.A = 19'sd3; ifc.B = -19'sd4; ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        dc = 0; o = '0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) begin
                ifc.A = 19'sd9; ifc.B = 19'sd9; ifc.start = 1'b1;
            end else begin
                ifc.start = 1'b0;
            end
            if (ifc.done === 1'b1) begin
                dc++; o = ifc.out;
            end
            @(negedge clk);
        end
        total++;
        if (dc !== 1 || o !== 19'h7FFF4) begin
            bad++; $display("FAIL start_while_busy: got pulses=%0d out=%h want 1 7fff4", dc, o);
        end
    endtask

    task automatic test_back_to_back();
        int last, gaps_ok, pulses;
        @(negedge clk);
        ifc.A = 19'sd3; ifc.B = 19'sd5; ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        last = -1; gaps_ok = 1; pulses = 0;
        for (int k = 1; k <= 70; k++) begin
            if (ifc.done === 1'b1) begin
                pulses++;
                if (last >= 0 && (k - last) != 21) gaps_ok = 0;
                if (ifc.out !== 19'd15) gaps_ok = 0;
                last = k;
            end
            @(negedge clk);
        end
        ifc.start = 1'b0;
        repeat (30) @(negedge clk);
        total++;
        if (pulses !== 3 || gaps_ok !== 1) begin
            bad++; $display("FAIL back_to_back: got pulses=%0d spacing_ok=%0d want 3 1", pulses, gaps_ok);
        end
    endtask

    task automatic test_random();
        logic signed [N-1:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            if (i % 5 == 1) a = N'($urandom_range(0, 40)) - 19'sd20;
            if (i % 5 == 2) b = N'($urandom_range(0, 40)) - 19'sd20;
            check_op("random", a, b);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        ifc.start = 1'b0; ifc.A = '0; ifc.B = '0;
        test_reset();
        test_reset_mid_run();
        test_directed();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplicador_iterativo.md
Name: multiplicador_iterativo

Overview:
- Multi-cycle signed integer multiplier for the Execute-stage ALU of the vector CPU; it is the inverse arithmetic unit of the ALU divider.
- Shift-add, radix-2, over operand magnitudes, with a final sign fix-up.
- Returns the low n bits of the product plus the standard ALU flag pair (overflow, car).
- Uses a start/busy/done handshake so the Execute stage can stall while a lane multiplies.

Parameters:
- n, 19, operand and result width in bits (two's complement).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  n  signed multiplicand; captured on an accepted start.
- B  input  n  signed multiplier; captured on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; out and overflow are valid from this cycle.
- out  output  n  low n bits of A*B, held until the next accepted start.
- overflow  output  1  signed product does not fit in n bits; held like out.
- car  output  1  tied 0; matches the ALU flag interface.

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, out=0, overflow=0; internal accumulator, counter and sign bit cleared.
- Reset mid-operation aborts the multiply. No done pulse follows, and outputs read 0.
- States:
  - IDLE: start=1 captures |A| and |B| into n-bit magnitude registers, sign = A[n-1]^B[n-1], clears the 2n-bit accumulator, sets counter=0, goes to RUN.
  - RUN: one multiplier bit per cycle. If mag_B[0]=1, acc += mag_A << counter. Then mag_B >>= 1 and counter++. After n iterations (counter==n-1 processed), goes to FIX.
  - FIX: P = sign ? -acc : acc (2n-bit two's complement). Registers out=P[n-1:0], overflow = ~(all bits of P[2n-1:n-1] equal). Asserts done for this single cycle, then returns to IDLE.
- Latency: start sampled on edge E0; busy=1 for cycles E0+1 .. E0+n+1; done=1 in cycle E0+n+1; next start accepted in cycle E0+n+2.
- busy stays high during the FIX/done cycle.
- Magnitude of -2^(n-1) is 2^(n-1). The magnitude registers are n bits unsigned, so this value is representable and needs no special case.
- start while busy=1: ignored. Operands are not re-captured and the sequence is unaffected.
- start held high continuously: a new operation starts each time IDLE is reached. done pulses once per operation.
- A or B may change after the capture edge without effect.
- Zero operand: normal n-cycle latency, no early exit. out=0, overflow=0.
- Sign of a zero product: -0 = 0 after negation, so no spurious overflow.
- car is a constant 0 in every state.

Decomposition:
- Shared ALU package holds:
  - typedef mul_state_t (IDLE, RUN, FIX), 2-bit enum;
  - localparam default ALU width 19;
  - counter width function $clog2(n).
- No sub-module. Counter, accumulator and FSM live in one block (about 150 lines).
- A wrapper may instantiate one instance per vector lane.

Test Plan:
- Reset mid-RUN: start A=5, B=7; assert rst at cycle 4 -> busy=0 immediately, no done pulse; after release, start A=5, B=7 -> out=35 (0x00023), overflow=0.
- Mixed signs: A=3, B=-4 -> done at cycle n+1=20 after start, out=0x7FFF4 (-12), overflow=0, car=0.
- Positive overflow: A=1000, B=1000 -> out=0x74240, overflow=1.
- Boundary: A=-262144, B=-1 -> out=0x40000, overflow=1. Then A=-262144, B=1 -> out=0x40000, overflow=0.
- Handshake: pulse start while busy with A=9, B=9 during the 3*-4 operation -> result stays 0x7FFF4, exactly one done pulse. Back-to-back start held high -> done pulses separated by 21 cycles.
- Zero/identity: A=0, B=-262144 -> out=0, overflow=0. A=262143, B=1 -> out=0x3FFFF, overflow=0.
